// File: rtl/cordic_angle_sequencer.sv
// rtl/cordic_angle_sequencer.sv - degree-sweep sequencer feeding binary angles and latency-matched tags to a CORDIC
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   cmd_valid/ready   sweep command handshake; ready only while idle
//   cmd_start_deg     first degree of the sweep (0..359)
//   cmd_stop_deg      last degree of the sweep (0..359), wraps through 0 if below start
//   cmd_step_deg      degree increment (1..359)
//   angle/angle_valid binary angle (2^32 = 360 deg) presented to the CORDIC
//   tag_valid/tag_deg degree belonging to the CORDIC output of this cycle
//   busy              sweep in progress (running or draining)
//   done              one-cycle pulse once the last tag has left the pipe
//   cmd_err           one-cycle pulse after an illegal command was rejected
module cordic_angle_sequencer #(
    parameter int CORDIC_LAT    = 16,
    parameter int ANGLE_PER_DEG = 11930465,
    parameter int DEG_W         = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DEG_W-1:0] cmd_start_deg,
    input  logic [DEG_W-1:0] cmd_stop_deg,
    input  logic [DEG_W-1:0] cmd_step_deg,
    output logic [31:0]      angle,
    output logic             angle_valid,
    output logic             tag_valid,
    output logic [DEG_W-1:0] tag_deg,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [DEG_W:0] FULL_TURN = (DEG_W + 1)'(360);
    localparam logic [31:0]    APD       = 32'(ANGLE_PER_DEG);

    state_t state;
    state_t state_nxt;

    logic [DEG_W-1:0] cur;
    logic [DEG_W-1:0] rem;
    logic [DEG_W-1:0] step;
    logic [DEG_W-1:0] angle_deg;

    logic [CORDIC_LAT-1:0] pipe_valid;
    logic [DEG_W-1:0]      pipe_deg [CORDIC_LAT];

    logic             accept;
    logic             cmd_legal;
    logic             last_sample;
    logic             pipe_empty;
    logic [DEG_W:0]   sum;
    logic [DEG_W:0]   span;
    logic [DEG_W-1:0] cur_nxt;
    logic [DEG_W-1:0] span_mod;
    logic [31:0]      prod;

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_legal = ({1'b0, cmd_start_deg} < FULL_TURN) &&
                       ({1'b0, cmd_stop_deg}  < FULL_TURN) &&
                       ({1'b0, cmd_step_deg}  < FULL_TURN) &&
                       (cmd_step_deg != '0);

    // Sweep length modulo 360 without a divider: stop+360-start lies in 1..719,
    // so a single conditional subtract normalises it.
    assign span     = {1'b0, cmd_stop_deg} + FULL_TURN - {1'b0, cmd_start_deg};
    assign span_mod = DEG_W'((span >= FULL_TURN) ? (span - FULL_TURN) : span);

    // Both operands are below 360, so one conditional subtract wraps the sum.
    assign sum     = {1'b0, cur} + {1'b0, step};
    assign cur_nxt = DEG_W'((sum >= FULL_TURN) ? (sum - FULL_TURN) : sum);

    // Only the low 32 bits of the product matter: the angle wraps at one turn.
    assign prod = 32'(cur) * APD;

    assign last_sample = (rem < step);

    // The pipe is empty only once the angle register and every tag stage are idle.
    assign pipe_empty = !angle_valid && (pipe_valid == '0);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && cmd_legal) state_nxt = RUN;
            RUN:     if (last_sample)         state_nxt = DRAIN;
            DRAIN:   if (pipe_empty)          state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            DRAIN:   done = pipe_empty;
            default: ;
        endcase
    end

    // Sweep datapath and angle register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur         <= '0;
            rem         <= '0;
            step        <= '0;
            angle       <= '0;
            angle_valid <= 1'b0;
            angle_deg   <= '0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err     <= accept && !cmd_legal;
            angle_valid <= (state == RUN);
            if (state == IDLE) begin
                if (accept && cmd_legal) begin
                    cur  <= cmd_start_deg;
                    rem  <= span_mod;
                    step <= cmd_step_deg;
                end
            end else if (state == RUN) begin
                angle     <= prod;
                angle_deg <= cur;
                if (!last_sample) begin
                    rem <= rem - step;
                    cur <= cur_nxt;
                end
            end
        end
    end

    // Tag pipe is fed from the angle register itself, so CORDIC_LAT stages give
    // exactly CORDIC_LAT cycles of delay relative to `angle`.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < CORDIC_LAT; i++) begin
                pipe_deg[i] <= '0;
            end
        end else begin
            pipe_valid  <= {pipe_valid[CORDIC_LAT-2:0], angle_valid};
            pipe_deg[0] <= angle_deg;
            for (int i = 1; i < CORDIC_LAT; i++) begin
                pipe_deg[i] <= pipe_deg[i-1];
            end
        end
    end

    assign tag_valid = pipe_valid[CORDIC_LAT-1];
    assign tag_deg   = pipe_deg[CORDIC_LAT-1];

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// tb/tb_cordic_angle_sequencer.sv - directed vector bench for cordic_angle_sequencer
module tb_cordic_angle_sequencer;

    localparam int LAT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_start_deg;
    logic [8:0]  cmd_stop_deg;
    logic [8:0]  cmd_step_deg;
    logic [31:0] angle;
    logic        angle_valid;
    logic        tag_valid;
    logic [8:0]  tag_deg;
    logic        busy;
    logic        done;
    logic        cmd_err;

    cordic_angle_sequencer #(
        .CORDIC_LAT   (LAT),
        .ANGLE_PER_DEG(11930465),
        .DEG_W        (9)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start_deg(cmd_start_deg),
        .cmd_stop_deg (cmd_stop_deg),
        .cmd_step_deg (cmd_step_deg),
        .angle        (angle),
        .angle_valid  (angle_valid),
        .tag_valid    (tag_valid),
        .tag_deg      (tag_deg),
        .busy         (busy),
        .done         (done),
        .cmd_err      (cmd_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [8:0]      start;
        logic [8:0]      stop;
        logic [8:0]      step;
        logic            err;
        logic            hold;
        logic [9:0]      n;
        logic [31:0]     first_angle;
        logic [8:0]      last;
        logic [2:0]      nchk;
        logic [4:0][8:0] tags;
    } vec_t;

    vec_t vecs [6];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    longint av_cyc [$];
    longint av_ang [$];
    longint tg_cyc [$];
    longint tg_deg [$];
    longint dn_cyc [$];
    longint er_cyc [$];
    int     busy_cnt;
    int     ready_bad;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (angle_valid) begin
                av_cyc.push_back(cyc);
                av_ang.push_back(longint'(angle));
            end
            if (tag_valid) begin
                tg_cyc.push_back(cyc);
                tg_deg.push_back(longint'(tag_deg));
            end
            if (done)    dn_cyc.push_back(cyc);
            if (cmd_err) er_cyc.push_back(cyc);
            if (busy)    busy_cnt = busy_cnt + 1;
            if (busy && cmd_ready) ready_bad = ready_bad + 1;
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic longint qget(input longint q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic vec_t mk(input int s, input int e, input int st, input bit err,
                                input bit hold, input int n, input logic [31:0] fa,
                                input int last, input int nchk, input int t0,
                                input int t1, input int t2, input int t3, input int t4);
        vec_t v;
        v.start       = 9'(s);
        v.stop        = 9'(e);
        v.step        = 9'(st);
        v.err         = err;
        v.hold        = hold;
        v.n           = 10'(n);
        v.first_angle = fa;
        v.last        = 9'(last);
        v.nchk        = 3'(nchk);
        v.tags[0]     = 9'(t0);
        v.tags[1]     = 9'(t1);
        v.tags[2]     = 9'(t2);
        v.tags[3]     = 9'(t3);
        v.tags[4]     = 9'(t4);
        return v;
    endfunction

    task automatic clear_log();
        av_cyc.delete();
        av_ang.delete();
        tg_cyc.delete();
        tg_deg.delete();
        dn_cyc.delete();
        er_cyc.delete();
        busy_cnt  = 0;
        ready_bad = 0;
    endtask

    task automatic issue(input logic [8:0] s, input logic [8:0] e, input logic [8:0] st,
                         output int acc);
        @(negedge clock);
        cmd_valid     = 1'b1;
        cmd_start_deg = s;
        cmd_stop_deg  = e;
        cmd_step_deg  = st;
        @(posedge clock);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int  acc;
        bit  seen;
        string p;
        p = $sformatf("v%0d", id);
        clear_log();
        issue(v.start, v.stop, v.step, acc);
        if (v.hold) begin
            // keep requesting with different fields; a busy sequencer must ignore it
            cmd_valid     = 1'b1;
            cmd_start_deg = 9'd100;
            cmd_stop_deg  = 9'd200;
            cmd_step_deg  = 9'd1;
        end
        seen = 1'b0;
        if (v.err) begin
            repeat (6) @(negedge clock);
            #1;
        end else begin
            for (int k = 0; k < 500; k++) begin
                @(negedge clock);
                #1;
                if (dn_cyc.size() > 0) begin
                    seen = 1'b1;
                    break;
                end
            end
            cmd_valid = 1'b0;
            check({p, "_done_seen"}, longint'(seen), 1);
        end
        repeat (3) @(negedge clock);
        #1;
        if (v.err) begin
            check({p, "_err_count"}, er_cyc.size(), 1);
            check({p, "_err_cycle"}, qget(er_cyc, 0), acc);
            check({p, "_no_samples"}, av_cyc.size(), 0);
            check({p, "_busy_cycles"}, busy_cnt, 0);
        end else begin
            check({p, "_sample_count"}, av_cyc.size(), longint'(v.n));
            check({p, "_tag_count"}, tg_cyc.size(), longint'(v.n));
            check({p, "_first_sample_cycle"}, qget(av_cyc, 0), acc + 1);
            check({p, "_samples_back_to_back"},
                  qget(av_cyc, av_cyc.size() - 1) - qget(av_cyc, 0), longint'(v.n) - 1);
            check({p, "_first_angle"}, qget(av_ang, 0), longint'(v.first_angle));
            check({p, "_first_tag_cycle"}, qget(tg_cyc, 0), acc + 1 + LAT);
            check({p, "_tags_back_to_back"},
                  qget(tg_cyc, tg_cyc.size() - 1) - qget(tg_cyc, 0), longint'(v.n) - 1);
            for (int i = 0; i < int'(v.nchk); i++) begin
                check($sformatf("%s_tag%0d", p, i), qget(tg_deg, i), longint'(v.tags[i]));
            end
            check({p, "_last_tag"}, qget(tg_deg, tg_deg.size() - 1), longint'(v.last));
            check({p, "_done_count"}, dn_cyc.size(), 1);
            check({p, "_done_cycle"}, qget(dn_cyc, 0), qget(tg_cyc, tg_cyc.size() - 1) + 1);
            check({p, "_no_err"}, er_cyc.size(), 0);
            if (v.n == 10'd360) begin
                check({p, "_angle_90"}, qget(av_ang, 90), 64'h4000001A);
                check({p, "_angle_180"}, qget(av_ang, 180), 64'h80000034);
            end
        end
        check({p, "_ready_while_busy"}, ready_bad, 0);
        check({p, "_busy_after"}, longint'(busy), 0);
        check({p, "_ready_after"}, longint'(cmd_ready), 1);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_angle"}, longint'(angle), 0);
        check({p, "_angle_valid"}, longint'(angle_valid), 0);
        check({p, "_tag_valid"}, longint'(tag_valid), 0);
        check({p, "_tag_deg"}, longint'(tag_deg), 0);
        check({p, "_busy"}, longint'(busy), 0);
        check({p, "_done"}, longint'(done), 0);
        check({p, "_cmd_err"}, longint'(cmd_err), 0);
        check({p, "_cmd_ready"}, longint'(cmd_ready), 1);
    endtask

    initial begin
        int  acc;
        bit  reached;

        //           start stop step err hold   n   first_angle    last nchk tags
        vecs[0] = mk( 45,  45,  1,  0,  0,   1, 32'h2000000D,   45,  1,  45,   0, 0, 0,  0);
        vecs[1] = mk(  0, 359,  1,  0,  0, 360, 32'h00000000,  359,  5,   0,   1, 2, 3,  4);
        vecs[2] = mk(350,  10,  5,  0,  0,   5, 32'd4175662750, 10,  5, 350, 355, 0, 5, 10);
        vecs[3] = mk(  0,  10,  4,  0,  1,   3, 32'h00000000,    8,  3,   0,   4, 8, 0,  0);
        vecs[4] = mk( 10,  20,  0,  1,  0,   0, 32'h00000000,    0,  0,   0,   0, 0, 0,  0);
        vecs[5] = mk(360,  20,  1,  1,  0,   0, 32'h00000000,    0,  0,   0,   0, 0, 0,  0);

        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_start_deg = '0;
        cmd_stop_deg  = '0;
        cmd_step_deg  = '0;
        clear_log();
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a long sweep, five cycles after the first sample
        clear_log();
        issue(9'd0, 9'd359, 9'd1, acc);
        reached = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            #1;
            if (av_cyc.size() >= 6) begin
                reached = 1'b1;
                break;
            end
        end
        check("midrst_reached", longint'(reached), 1);
        check("midrst_sample_cycle", qget(av_cyc, 5), acc + 6);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clock);
        clear_log();
        reset = 1'b0;
        repeat (30) @(negedge clock);
        #1;
        check("midrst_no_done", dn_cyc.size(), 0);
        check("midrst_no_tags", tg_cyc.size(), 0);
        check("midrst_no_samples", av_cyc.size(), 0);
        check("midrst_idle_ready", longint'(cmd_ready), 1);

        run_vec(vecs[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_angle_sequencer.md
Name: cordic_angle_sequencer

Overview:
- Upstream stage of the CORDIC sin/cos pipeline. Accepts a degree-sweep command over a valid/ready handshake and converts each degree to the 32-bit binary angle the CORDIC consumes (2^32 = 360 deg).
- Issues one angle per clock and carries a degree tag through a shift pipe matched to CORDIC latency, so downstream logic knows which degree each Xout/Yout sample belongs to.

Parameters:
- CORDIC_LAT, 16, clock cycles from the `angle` register to a valid CORDIC Xout/Yout; tag pipe depth.
- ANGLE_PER_DEG, 11930465, round(2^32/360); degree-to-binary-angle scale constant.
- DEG_W, 9, width of all degree fields.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_start_deg  input  DEG_W  first degree, 0..359
- cmd_stop_deg  input  DEG_W  last degree, 0..359
- cmd_step_deg  input  DEG_W  increment, 1..359
- angle  output  32  binary angle to CORDIC
- angle_valid  output  1  `angle` holds a new sample this cycle
- tag_valid  output  1  CORDIC output this cycle corresponds to an issued sample
- tag_deg  output  DEG_W  degree of that sample
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when the sweep has fully drained
- cmd_err  output  1  one-cycle pulse when an illegal command is rejected

Behaviour:
- Reset values: angle=0, angle_valid=0, tag_valid=0, tag_deg=0, busy=0, done=0, cmd_err=0, cmd_ready=1, state=IDLE. Tag pipe is cleared.
- Reset mid-sweep aborts immediately. No done pulse is generated.
- FSM states are IDLE, RUN and DRAIN. cmd_ready=1 only in IDLE.
- IDLE, command accepted, illegal fields (any field ≥360 or step==0):
  - cmd_err pulses on the next cycle.
  - State stays IDLE.
- IDLE, command accepted, legal fields:
  - Latch the command and set cur=start and rem=(stop-start) mod 360.
  - Go to RUN.
- RUN, each cycle:
  - Registered outputs: angle <= cur*ANGLE_PER_DEG (truncated to 32 bits) and angle_valid <= 1.
  - Push cur into the tag pipe.
  - If rem < step, this is the last sample; go to DRAIN.
  - Otherwise rem <= rem-step and cur <= cur+step, subtracting 360 if the sum is ≥360. No divider is used.
- Sample count per sweep is floor(((stop-start) mod 360)/step)+1. start==stop gives exactly one sample.
- Issue timing:
  - If the command is accepted at edge T, the first angle_valid is high in the cycle after edge T+1.
  - Samples follow back-to-back with no gaps.
- DRAIN:
  - angle_valid=0; `angle` holds its last value, because the CORDIC has no valid input.
  - Wait until the tag pipe holds no valid entries, then pulse done for one cycle and go to IDLE.
  - cmd_ready rises in the same cycle as done deasserts.
- Tag pipe:
  - CORDIC_LAT stages of {valid, deg}.
  - tag_valid/tag_deg equal angle_valid/cur delayed by exactly CORDIC_LAT cycles relative to the `angle` register.
  - Bubbles propagate as tag_valid=0.
- cmd_valid while busy is ignored. Fields are sampled only at acceptance; later input changes have no effect on the running sweep.
- All arithmetic is unsigned. The degree add uses DEG_W+1 bits before the modulo compare.

Test Plan:
- Single 45 deg (start=stop=45, step=1) -> exactly one angle_valid with angle=0x2000000D; tag_valid with tag_deg=45 exactly 16 cycles later; done one cycle after that tag.
- Full sweep 0..359 step 1 -> 360 consecutive angle_valid cycles. angle at 90 = 0x4000001A and at 180 = 0x80000034. 360 tag_valid cycles, then one done; busy low afterwards.
- Wrap sweep start=350, stop=10, step=5 -> tags 350,355,0,5,10 in order (5 samples), then done.
- Non-dividing step 0->10 step 4 -> tags 0,4,8 only. cmd_valid held high during the run is ignored (cmd_ready=0).
- Illegal commands (step=0; start=360) -> cmd_err pulse each, no angle_valid, busy stays 0, cmd_ready stays 1.
- Reset asserted mid-sweep, 5 cycles after the first sample -> all outputs return to reset values asynchronously, no done, tag pipe empty. A new command after reset runs normally.
